// File: rtl/enc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// enc_ctrl_pkg
// Shared definitions for the message sequencer that drives the
// single-character encryption core:
//   - seq_state_t : sequencer FSM states
//   - MODE_ENC / MODE_IDLE : core mode encodings
//   - sat_inc8    : saturating 8-bit increment used by the error counter
// ----------------------------------------------------------------------------
package enc_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      EMIT,
      RELEASE,
      DONE
   } seq_state_t;

   localparam logic [1:0] MODE_ENC  = 2'b10;
   localparam logic [1:0] MODE_IDLE = 2'b00;

   // Adds inc to v, sticking at 8'hFF instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
      if (inc && (v != 8'hFF)) begin
         return v + 8'd1;
      end
      return v;
   endfunction

endpackage

// File: rtl/enc_msg_sequencer_if.sv
// ----------------------------------------------------------------------------
// enc_msg_sequencer_if
// Host-side byte streams of the message sequencer.
//   ptxt_valid / ptxt_data / ptxt_ready : plaintext into the sequencer
//   ctxt_valid / ctxt_data / ctxt_err / ctxt_last / ctxt_ready :
//                                          ciphertext out of the sequencer
// Modports:
//   master : host side (drives plaintext, accepts ciphertext)
//   slave  : sequencer side
// ----------------------------------------------------------------------------
interface enc_msg_sequencer_if;

   logic       ptxt_valid;
   logic [7:0] ptxt_data;
   logic       ptxt_ready;

   logic       ctxt_valid;
   logic [7:0] ctxt_data;
   logic       ctxt_err;
   logic       ctxt_last;
   logic       ctxt_ready;

   modport master (
      output ptxt_valid, ptxt_data, ctxt_ready,
      input  ptxt_ready, ctxt_valid, ctxt_data, ctxt_err, ctxt_last
   );

   modport slave (
      input  ptxt_valid, ptxt_data, ctxt_ready,
      output ptxt_ready, ctxt_valid, ctxt_data, ctxt_err, ctxt_last
   );

endinterface

// File: rtl/enc_msg_sequencer_watchdog.sv
// ----------------------------------------------------------------------------
// enc_watchdog
// Per-character watchdog: clear/enable up-counter saturating at
// TIMEOUT_CYCLES.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the count (priority over en)
//   en       : count this cycle
//   tc       : terminal count; high while the count sits one below
//              TIMEOUT_CYCLES, i.e. on the cycle whose increment reaches
//              TIMEOUT_CYCLES. Kept independent of en so the owner can
//              combine it without a combinational loop.
// ----------------------------------------------------------------------------
module enc_watchdog #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != CNT_W'(TIMEOUT_CYCLES))) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/enc_msg_sequencer.sv
// ----------------------------------------------------------------------------
// enc_msg_sequencer
// Feeds a message byte-by-byte through the single-character encryption
// core and streams the ciphertext out with last/error sideband.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start_msg     : begin a message (sampled in IDLE only)
//   msg_len       : character count, latched with start_msg
//   key_in        : key, latched with start_msg
//   abort         : cancel from any state, back to IDLE next cycle
//   strm          : plaintext / ciphertext streams (slave modport)
//   core_mode, core_ptxt, core_key     : to the encryption core
//   core_ctxt, core_c_ready, core_err  : from the encryption core
//   busy          : FSM not in IDLE
//   done          : one-cycle pulse after a message completes
//   err_count     : invalid characters in this message (saturating)
//   timeout_err   : sticky core timeout, cleared by the next start_msg
// ----------------------------------------------------------------------------
module enc_msg_sequencer
   import enc_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int LEN_W          = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_msg,
   input  logic [LEN_W-1:0]     msg_len,
   input  logic [7:0]           key_in,
   input  logic                 abort,
   enc_msg_sequencer_if.slave   strm,
   output logic [1:0]           core_mode,
   output logic [7:0]           core_ptxt,
   output logic [7:0]           core_key,
   input  logic [7:0]           core_ctxt,
   input  logic                 core_c_ready,
   input  logic                 core_err,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           err_count,
   output logic                 timeout_err
);

   seq_state_t       state, state_nxt;
   logic [LEN_W-1:0] rem;
   logic [7:0]       ctxt_data_q;
   logic             ctxt_err_q;
   logic             ctxt_last_q;
   logic             wd_clr, wd_en, wd_tc;

   enc_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk (clk),
      .rst (rst),
      .clr (wd_clr),
      .en  (wd_en),
      .tc  (wd_tc)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_nxt       = state;
      core_mode       = MODE_IDLE;
      strm.ptxt_ready = 1'b0;
      strm.ctxt_valid = 1'b0;
      wd_clr          = 1'b0;
      wd_en           = 1'b0;

      case (state)
         IDLE: begin
            if (start_msg) begin
               state_nxt = (msg_len == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            strm.ptxt_ready = 1'b1;
            if (strm.ptxt_valid) begin
               wd_clr    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            core_mode = MODE_ENC;
            if (core_c_ready) begin
               state_nxt = EMIT;
            end else begin
               wd_en = 1'b1;
               if (wd_tc) begin
                  state_nxt = DONE;
               end
            end
         end
         EMIT: begin
            strm.ctxt_valid = 1'b1;
            if (strm.ctxt_ready) begin
               state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            // Waiting for C_ready to drop covers both pulse- and level-style
            // cores before the next request is raised.
            if (!core_c_ready) begin
               state_nxt = (rem != '0) ? FETCH : DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (abort) begin
         state_nxt = IDLE;
      end
   end

   // Message registers, captured results and status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem         <= '0;
         core_ptxt   <= '0;
         core_key    <= '0;
         ctxt_data_q <= '0;
         ctxt_err_q  <= 1'b0;
         ctxt_last_q <= 1'b0;
         err_count   <= '0;
         timeout_err <= 1'b0;
         done        <= 1'b0;
      end else begin
         // done trails the DONE state by one cycle; an abort cancels it.
         done <= (state == DONE) && !abort;
         if (!abort) begin
            case (state)
               IDLE: begin
                  if (start_msg) begin
                     core_key    <= key_in;
                     rem         <= msg_len;
                     err_count   <= '0;
                     timeout_err <= 1'b0;
                  end
               end
               FETCH: begin
                  if (strm.ptxt_valid) begin
                     core_ptxt <= strm.ptxt_data;
                  end
               end
               ISSUE: begin
                  if (core_c_ready) begin
                     ctxt_data_q <= core_ctxt;
                     ctxt_err_q  <= core_err;
                     ctxt_last_q <= (rem == LEN_W'(1));
                     if (rem != '0) begin
                        rem <= rem - LEN_W'(1);
                     end
                     err_count <= sat_inc8(err_count, core_err);
                  end else if (wd_tc) begin
                     timeout_err <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign strm.ctxt_data = ctxt_data_q;
   assign strm.ctxt_err  = ctxt_err_q;
   assign strm.ctxt_last = ctxt_last_q;
   assign busy           = (state != IDLE);

endmodule
